// File: rtl/shiftreg_tx_arbiter_if.sv
// Handshake and serial-output bundle for shiftreg_tx_arbiter.
// The slave side is the arbiter; the master side is the producers/consumer.
`timescale 1ns/1ps
interface shiftreg_tx_arbiter_if #(
  parameter int DATA_WIDTH = 4
);
  logic                  req0_valid;
  logic [DATA_WIDTH-1:0] req0_data;
  logic                  req0_ready;
  logic                  req1_valid;
  logic [DATA_WIDTH-1:0] req1_data;
  logic                  req1_ready;
  logic                  sout_data;
  logic                  sout_valid;
  logic                  sout_first;
  logic                  sout_last;
  logic                  sout_src;
  logic                  busy;

  modport slave (
    input  req0_valid, req0_data, req1_valid, req1_data,
    output req0_ready, req1_ready,
    output sout_data, sout_valid, sout_first, sout_last, sout_src, busy
  );

  modport master (
    output req0_valid, req0_data, req1_valid, req1_data,
    input  req0_ready, req1_ready,
    input  sout_data, sout_valid, sout_first, sout_last, sout_src, busy
  );
endinterface

// File: rtl/shiftreg_tx_arbiter.sv
// Two-requester round-robin arbiter feeding one PISO shift register that
// streams each granted word MSB-first with first/last framing and an idle gap.
`timescale 1ns/1ps
module shiftreg_tx_arbiter #(
  parameter int DATA_WIDTH = 4,
  parameter int GAP_CYCLES = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  shiftreg_tx_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

  localparam int CNT_W = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [GAP_W-1:0]      gap_q, gap_d;
  logic                  ptr_q, ptr_d;
  logic                  src_q, src_d;
  logic                  sout_valid_q, sout_valid_d;
  logic                  sout_data_q, sout_data_d;
  logic                  sout_first_q, sout_first_d;
  logic                  sout_last_q, sout_last_d;
  logic                  busy_q, busy_d;
  logic                  gnt0, gnt1;
  logic                  in_shift_d;

  // ptr_q == 0 gives requester 0 priority, 1 gives requester 1 priority.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (state_q == IDLE) begin
      if (!ptr_q) begin
        gnt0 = bus.req0_valid;
        gnt1 = !bus.req0_valid && bus.req1_valid;
      end else begin
        gnt1 = bus.req1_valid;
        gnt0 = !bus.req1_valid && bus.req0_valid;
      end
    end
  end

  assign bus.req0_ready = gnt0 && !rst;
  assign bus.req1_ready = gnt1 && !rst;

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    gap_d   = gap_q;
    ptr_d   = ptr_q;
    src_d   = src_q;
    case (state_q)
      IDLE: begin
        if (gnt0 || gnt1) begin
          shreg_d = gnt1 ? bus.req1_data : bus.req0_data;
          cnt_d   = '0;
          src_d   = gnt1;
          ptr_d   = !gnt1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt_q == CNT_LAST) begin
          gap_d   = '0;
          state_d = (GAP_CYCLES > 0) ? GAP : IDLE;
        end else begin
          shreg_d = shreg_q << 1;
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      GAP: begin
        if (gap_q == GAP_LAST) begin
          state_d = IDLE;
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs are computed from next-state values so they land in the
    // same cycle as the state they describe.
    in_shift_d   = (state_d == SHIFT);
    sout_valid_d = in_shift_d;
    sout_data_d  = in_shift_d && shreg_d[DATA_WIDTH-1];
    sout_first_d = in_shift_d && (cnt_d == '0);
    sout_last_d  = in_shift_d && (cnt_d == CNT_LAST);
    busy_d       = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      shreg_q      <= '0;
      cnt_q        <= '0;
      gap_q        <= '0;
      ptr_q        <= 1'b0;
      src_q        <= 1'b0;
      sout_valid_q <= 1'b0;
      sout_data_q  <= 1'b0;
      sout_first_q <= 1'b0;
      sout_last_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      cnt_q        <= cnt_d;
      gap_q        <= gap_d;
      ptr_q        <= ptr_d;
      src_q        <= src_d;
      sout_valid_q <= sout_valid_d;
      sout_data_q  <= sout_data_d;
      sout_first_q <= sout_first_d;
      sout_last_q  <= sout_last_d;
      busy_q       <= busy_d;
    end
  end

  assign bus.sout_valid = sout_valid_q;
  assign bus.sout_data  = sout_data_q;
  assign bus.sout_first = sout_first_q;
  assign bus.sout_last  = sout_last_q;
  assign bus.sout_src   = src_q;
  assign bus.busy       = busy_q;

endmodule
